xfc_tx_framer: RTL and testbench
================================

# xfc_tx_framer

Packet framer sitting directly upstream of the RIFFA Xillybus-compatible adapter's sink FIFO on the card-to-host path. It accepts a valid/ready word stream from user logic and buffers one packet. It then writes a length-header word followed by the buffered payload into the sink FIFO, which is the format the adapter's TX state machine consumes. Packets longer than the buffer are split into several frames.

## Interface
- C_PCI_DATA_WIDTH, 64, word width; only 64 and 128 are legal, any other value is a fatal elaboration error.
- C_MAX_BEATS, 512, payload buffer depth in words; must be a power of two, minimum 2.
- CLK  in  1  single clock, the RIFFA channel clock.
- RST_N  in  1  reset, asynchronous and active-low.
- IN_D  in  C_PCI_DATA_WIDTH  payload word.
- IN_VALID  in  1  IN_D valid.
- IN_LAST  in  1  IN_D is the final word of the packet.
- IN_READY  out  1  framer accepts a word this cycle.
- FIFO_W_WREN  out  1  write strobe to the sink FIFO.
- FIFO_W_FULL  in  1  sink FIFO full.
- FIFO_W_D  out  C_PCI_DATA_WIDTH  word to the sink FIFO.
- FRAME_SPLIT  out  1  one-cycle pulse when a frame is closed at C_MAX_BEATS without IN_LAST.
- FRAMES_SENT  out  32  count of completed frames; wraps at 2^32.

## Operation
- The state machine has three states: FILL, HDR and DRAIN. Reset state is FILL. The state is one-hot with 3 bits.
- **FILL**
  - IN_READY=1.
  - A word is accepted when IN_VALID&IN_READY. It is written to buffer[wr_cnt], and wr_cnt increments.
  - wr_cnt is ADDR_W+1 bits wide, where ADDR_W=clog2(C_MAX_BEATS).
  - Go to HDR on an accepted word if IN_LAST=1, or if the word brings wr_cnt to C_MAX_BEATS.
  - If the word reached C_MAX_BEATS with IN_LAST=0, pulse FRAME_SPLIT in the following cycle.
  - A frame never has zero words.
- **HDR**
  - IN_READY=0.
  - FIFO_W_D = length header, zero-extended to C_PCI_DATA_WIDTH:
    - width 64: header = N, the frame's word count.
    - width 128: header = 2N, counted in 64-bit units.
  - FIFO_W_WREN = ~FIFO_W_FULL. On a write, go to DRAIN.
- **DRAIN**
  - IN_READY=0.
  - FIFO_W_D = buffer[rd_ptr]. FIFO_W_WREN = ~FIFO_W_FULL.
  - Each write increments rd_ptr.
  - On the write of word N-1:
    - go to FILL;
    - clear wr_cnt and rd_ptr;
    - increment FRAMES_SPLIT's companion counter FRAMES_SENT.
- FIFO_W_WREN is never asserted while FIFO_W_FULL=1. This matches the adapter, which samples FULL in the same cycle.
- The buffer uses a registered-read RAM. The read address is prefetched so that FIFO_W_D already holds the correct word when a write strobe fires. The RAM output has no reset.
- A split packet's next word starts a new frame, with its own header, once the framer returns to FILL.

## Timing
- **Reset values:** IN_READY=0, FIFO_W_WREN=0, FRAME_SPLIT=0, FRAMES_SENT=0, wr_cnt=0, rd_ptr=0.
- IN_READY rises on the first CLK edge after RST_N deasserts.
- **Latency** (last word accepted at cycle t, FIFO never full):
  - header written at t+1;
  - word k written at t+2+k;
  - IN_READY=1 again at t+N+2.
- No bubbles between header and payload unless FIFO_W_FULL forces them. FULL stalls in place: FIFO_W_D is held and rd_ptr is not advanced.
- FULL toggling every cycle must give exactly N+1 writes with correct order and data.
- IN_READY and FIFO_W_WREN are never both 1. Input and output phases do not overlap.
- **Reset asserted mid-frame:** all state is cleared asynchronously and the partial frame is discarded. No header is emitted for it after reset.
- FRAME_SPLIT and the FRAMES_SENT increment are registered, one cycle after the qualifying event.

## Structure
- Shared package xfc_pkg holds:
  - the state encodings FILL/HDR/DRAIN;
  - the header-construction function hdr_len(N, width), covering both the 64-bit and 128-bit rules.
- Sub-module xfc_frame_ram: simple dual-port RAM, depth C_MAX_BEATS, width C_PCI_DATA_WIDTH, one write port, registered read port.

## Test plan
- **Width 64, single 4-word packet** 0x11..0x44 with IN_LAST on 0x44, FULL=0 -> FIFO sees 4, 0x11, 0x22, 0x33, 0x44 on consecutive cycles t+1..t+5; FRAMES_SENT=1.
- **Width 128, 3-word packet** -> header word = 6, then the 3 words in order; IN_READY low for exactly 4 cycles after the last word.
- **C_MAX_BEATS=4, 6-word packet** -> frame (4, w0..w3) with FRAME_SPLIT pulsed once, then frame (2, w4, w5); FRAMES_SENT=2.
- **FIFO_W_FULL backpressure** held high 3 cycles during HDR, then toggling every cycle during DRAIN -> no write while FULL; exact sequence header, w0..wN-1; FIFO_W_D stable across stalls.
- **RST_N asserted** after 2 words of a 5-word packet -> outputs at reset values immediately; after release, a new 1-word packet yields exactly (1, w).
- **1-word packet** with IN_LAST on the first word -> header 1 at t+1, word at t+2, IN_READY high at t+3.

Source files
------------

// File: rtl/xfc_pkg.sv
// Shared definitions for the card-to-host packet framer: FSM state encodings
// and the length-header rule used for both supported data widths.
package xfc_pkg;

    // One-hot framer states: buffer input, emit header, stream buffered payload
    typedef enum logic [2:0] {
        FILL  = 3'b001,
        HDR   = 3'b010,
        DRAIN = 3'b100
    } xfc_state_t;

    // Header length: word count at 64 bits, 64-bit unit count at 128 bits
    function automatic logic [31:0] hdr_len(input logic [31:0] n, input int width);
        if (width == 128) begin
            return n << 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/xfc_frame_ram.sv
// Payload buffer for one frame: simple dual-port RAM with one write port and
// a registered read port. The read data register is deliberately not reset.
module xfc_frame_ram #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 512,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              WE,
    input  logic [ADDR_W-1:0] WADDR,
    input  logic [DATA_W-1:0] WDATA,
    input  logic [ADDR_W-1:0] RADDR,
    output logic [DATA_W-1:0] RDATA
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write accepted payload words; read is registered so data lags address by one cycle
    always_ff @(posedge CLK) begin
        if (WE) begin
            mem[WADDR] <= WDATA;
        end
        RDATA <= mem[RADDR];
    end

endmodule

// File: rtl/xfc_tx_framer.sv
// Card-to-host framer: buffers one packet (or C_MAX_BEATS words of it), then
// writes a length header followed by the buffered payload into the sink FIFO.
// Input and output phases never overlap, so the FIFO sees back-to-back words
// unless FIFO_W_FULL stalls it.
module xfc_tx_framer
    import xfc_pkg::*;
#(
    parameter int C_PCI_DATA_WIDTH = 64,
    parameter int C_MAX_BEATS      = 512
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    input  logic [C_PCI_DATA_WIDTH-1:0] IN_D,
    input  logic                        IN_VALID,
    input  logic                        IN_LAST,
    output logic                        IN_READY,
    output logic                        FIFO_W_WREN,
    input  logic                        FIFO_W_FULL,
    output logic [C_PCI_DATA_WIDTH-1:0] FIFO_W_D,
    output logic                        FRAME_SPLIT,
    output logic [31:0]                 FRAMES_SENT
);

    localparam int ADDR_W = $clog2(C_MAX_BEATS);
    localparam int CNT_W  = ADDR_W + 1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(C_MAX_BEATS - 1);

    if (!(C_PCI_DATA_WIDTH == 64 || C_PCI_DATA_WIDTH == 128)) begin : g_bad_width
        $fatal(1, "xfc_tx_framer: C_PCI_DATA_WIDTH must be 64 or 128");
    end
    if (C_MAX_BEATS < 2 || (C_MAX_BEATS & (C_MAX_BEATS - 1)) != 0) begin : g_bad_depth
        $fatal(1, "xfc_tx_framer: C_MAX_BEATS must be a power of two, at least 2");
    end

    xfc_state_t                  state;
    xfc_state_t                  state_nxt;
    logic [CNT_W-1:0]            wr_cnt;
    logic [ADDR_W-1:0]           rd_ptr;
    logic [ADDR_W-1:0]           rd_ptr_nxt;
    logic                        ready_en;
    logic                        accept;
    logic                        last_drain;
    logic                        split_evt;
    logic [31:0]                 hdr;
    logic [C_PCI_DATA_WIDTH-1:0] ram_q;

    // The read address is the pointer's next value, so the registered RAM
    // output already holds buffer[rd_ptr] whenever a write strobe can fire.
    xfc_frame_ram #(
        .DATA_W (C_PCI_DATA_WIDTH),
        .DEPTH  (C_MAX_BEATS)
    ) u_ram (
        .CLK   (CLK),
        .WE    (accept),
        .WADDR (wr_cnt[ADDR_W-1:0]),
        .WDATA (IN_D),
        .RADDR (rd_ptr_nxt),
        .RDATA (ram_q)
    );

    // Next-state, handshake and FIFO-side outputs for the fill/header/drain sequence
    always_comb begin
        state_nxt   = state;
        IN_READY    = 1'b0;
        FIFO_W_WREN = 1'b0;
        FIFO_W_D    = ram_q;
        rd_ptr_nxt  = rd_ptr;
        accept      = 1'b0;
        last_drain  = 1'b0;
        split_evt   = 1'b0;
        hdr         = hdr_len(32'(wr_cnt), C_PCI_DATA_WIDTH);
        unique case (state)
            FILL: begin
                IN_READY = ready_en;
                accept   = IN_VALID & ready_en;
                if (accept && (IN_LAST || wr_cnt == LAST_SLOT)) begin
                    state_nxt = HDR;
                end
                split_evt = accept & ~IN_LAST & (wr_cnt == LAST_SLOT);
            end
            HDR: begin
                FIFO_W_WREN = ~FIFO_W_FULL;
                FIFO_W_D    = {{(C_PCI_DATA_WIDTH-32){1'b0}}, hdr};
                if (!FIFO_W_FULL) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                FIFO_W_WREN = ~FIFO_W_FULL;
                if (!FIFO_W_FULL) begin
                    if ({1'b0, rd_ptr} == wr_cnt - CNT_ONE) begin
                        last_drain = 1'b1;
                        state_nxt  = FILL;
                        rd_ptr_nxt = '0;
                    end else begin
                        rd_ptr_nxt = rd_ptr + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = FILL;
            end
        endcase
    end

    // State, buffer pointers and the post-reset ready enable
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= FILL;
            wr_cnt   <= '0;
            rd_ptr   <= '0;
            ready_en <= 1'b0;
        end else begin
            state    <= state_nxt;
            rd_ptr   <= rd_ptr_nxt;
            ready_en <= 1'b1;
            if (accept) begin
                wr_cnt <= wr_cnt + CNT_ONE;
            end else if (last_drain) begin
                wr_cnt <= '0;
            end
        end
    end

    // Registered status: split pulse and completed-frame counter
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            FRAME_SPLIT <= 1'b0;
            FRAMES_SENT <= '0;
        end else begin
            FRAME_SPLIT <= split_evt;
            if (last_drain) begin
                FRAMES_SENT <= FRAMES_SENT + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_xfc_tx_framer.sv
// Directed bench for xfc_tx_framer: three instances (64/512, 128/512, 64/4)
// share clock, reset and data; a negedge monitor logs every FIFO write with
// the clock edge that commits it.
module tb_xfc_tx_framer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] in_d;
    logic [2:0]   in_valid;
    logic [2:0]   in_last;
    logic [2:0]   full;
    logic [2:0]   ready;
    logic [2:0]   wren;
    logic [2:0]   split;
    logic [63:0]  a_fd;
    logic [127:0] b_fd;
    logic [63:0]  c_fd;
    logic [31:0]  a_sent;
    logic [31:0]  b_sent;
    logic [31:0]  c_sent;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [127:0] qa[$];
    logic [127:0] qb[$];
    logic [127:0] qc[$];
    int           sa[$];
    int           sb[$];
    int           sc[$];
    int           c_splits;
    int           c_split_at;
    logic         c_prev_stall;
    logic [63:0]  c_prev_fd;
    int           acc[16];

    // Free-running clock
    always #5 clk = ~clk;

    // Cycle index of the most recent rising edge
    always @(posedge clk) cyc <= cyc + 1;

    xfc_tx_framer #(.C_PCI_DATA_WIDTH(64), .C_MAX_BEATS(512)) dut_a (
        .CLK(clk), .RST_N(rst_n), .IN_D(in_d[63:0]), .IN_VALID(in_valid[0]),
        .IN_LAST(in_last[0]), .IN_READY(ready[0]), .FIFO_W_WREN(wren[0]),
        .FIFO_W_FULL(full[0]), .FIFO_W_D(a_fd), .FRAME_SPLIT(split[0]),
        .FRAMES_SENT(a_sent));

    xfc_tx_framer #(.C_PCI_DATA_WIDTH(128), .C_MAX_BEATS(512)) dut_b (
        .CLK(clk), .RST_N(rst_n), .IN_D(in_d), .IN_VALID(in_valid[1]),
        .IN_LAST(in_last[1]), .IN_READY(ready[1]), .FIFO_W_WREN(wren[1]),
        .FIFO_W_FULL(full[1]), .FIFO_W_D(b_fd), .FRAME_SPLIT(split[1]),
        .FRAMES_SENT(b_sent));

    xfc_tx_framer #(.C_PCI_DATA_WIDTH(64), .C_MAX_BEATS(4)) dut_c (
        .CLK(clk), .RST_N(rst_n), .IN_D(in_d[63:0]), .IN_VALID(in_valid[2]),
        .IN_LAST(in_last[2]), .IN_READY(ready[2]), .FIFO_W_WREN(wren[2]),
        .FIFO_W_FULL(full[2]), .FIFO_W_D(c_fd), .FRAME_SPLIT(split[2]),
        .FRAMES_SENT(c_sent));

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] mkWord(input logic [63:0] seed, input int i);
        return {seed ^ 64'hA5A5_0000_0000_5A5A ^ 64'(i), seed + 64'(i) * 64'h11};
    endfunction

    // Send n words to instance sel; records the accept edge of each word
    task automatic applyStimulus(input int sel, input int n, input logic [63:0] seed,
                                 input bit with_last, output int t_last);
        int waited;
        t_last = 0;
        for (int i = 0; i < n; i++) begin
            in_d          = mkWord(seed, i);
            in_valid[sel] = 1'b1;
            in_last[sel]  = with_last && (i == n - 1);
            waited        = 0;
            @(negedge clk);
            while (!ready[sel] && waited < 100) begin
                @(negedge clk);
                waited++;
            end
            checkOutput("ready_before_accept", 128'(ready[sel]), 128'd1);
            @(posedge clk);
            #1;
            acc[i] = cyc;
            t_last = cyc;
        end
        in_valid[sel] = 1'b0;
        in_last[sel]  = 1'b0;
    endtask

    // Wait for IN_READY; returns the edge at which it is seen high
    task automatic waitIdle(input int sel, output int t_ready);
        int waited = 0;
        @(negedge clk);
        while (!ready[sel] && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("idle_timeout", 128'(ready[sel]), 128'd1);
        t_ready = cyc + 1;
        @(posedge clk);
        #1;
    endtask

    // Pop the oldest logged write of instance sel and compare data and commit edge
    task automatic expectWrite(input int sel, input string tag, input logic [127:0] exp, input int exp_at);
        logic [127:0] v;
        int           s;
        int           sz;
        v  = '0;
        s  = 0;
        sz = (sel == 0) ? qa.size() : (sel == 1) ? qb.size() : qc.size();
        checkOutput({tag, "_present"}, 128'(sz > 0), 128'd1);
        if (sz > 0) begin
            if (sel == 0) begin v = qa.pop_front(); s = sa.pop_front(); end
            else if (sel == 1) begin v = qb.pop_front(); s = sb.pop_front(); end
            else begin v = qc.pop_front(); s = sc.pop_front(); end
            checkOutput(tag, v, exp);
            checkOutput({tag, "_cycle"}, 128'(s), 128'(exp_at));
        end
    endtask

    task automatic clearLogs();
        qa.delete(); qb.delete(); qc.delete();
        sa.delete(); sb.delete(); sc.delete();
    endtask

    // Log FIFO writes and check the always-true output invariants away from the edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (wren[0]) begin qa.push_back({64'd0, a_fd}); sa.push_back(cyc + 1); end
            if (wren[1]) begin qb.push_back(b_fd);          sb.push_back(cyc + 1); end
            if (wren[2]) begin qc.push_back({64'd0, c_fd}); sc.push_back(cyc + 1); end
            if (split[2]) begin
                c_splits++;
                c_split_at = cyc + 1;
            end
            checkOutput("split_ab_never", 128'(split[1:0]), 128'd0);
            for (int i = 0; i < 3; i++) begin
                if (full[i])  checkOutput("wren_while_full", 128'(wren[i]), 128'd0);
                if (ready[i]) checkOutput("ready_with_wren", 128'(wren[i]), 128'd0);
            end
            if (c_prev_stall && !ready[2]) begin
                checkOutput("fd_held_in_stall", {64'd0, c_fd}, {64'd0, c_prev_fd});
            end
            c_prev_stall = full[2] && !ready[2];
            c_prev_fd    = c_fd;
        end else begin
            c_prev_stall = 1'b0;
        end
    end

    // Directed test sequence
    initial begin
        int t;
        int tr;
        int splits_before;
        rst_n        = 1'b0;
        in_d         = '0;
        in_valid     = '0;
        in_last      = '0;
        full         = '0;
        c_splits     = 0;
        c_split_at   = 0;
        c_prev_stall = 1'b0;
        c_prev_fd    = '0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_ready", 128'(ready), 128'd0);
        checkOutput("rst_wren",  128'(wren),  128'd0);
        checkOutput("rst_split", 128'(split), 128'd0);
        checkOutput("rst_sent_a", 128'(a_sent), 128'd0);
        checkOutput("rst_sent_c", 128'(c_sent), 128'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("ready_before_first_edge", 128'(ready), 128'd0);
        @(posedge clk);
        #1;
        checkOutput("ready_after_first_edge", 128'(ready), 128'd7);

        // Width 64: 4-word packet
        clearLogs();
        applyStimulus(0, 4, 64'h11, 1'b1, t);
        waitIdle(0, tr);
        checkOutput("t1_ready_back", 128'(tr), 128'(t + 6));
        expectWrite(0, "t1_hdr", 128'd4,    t + 1);
        expectWrite(0, "t1_w0",  128'h11,   t + 2);
        expectWrite(0, "t1_w1",  128'h22,   t + 3);
        expectWrite(0, "t1_w2",  128'h33,   t + 4);
        expectWrite(0, "t1_w3",  128'h44,   t + 5);
        checkOutput("t1_extra", 128'(qa.size()), 128'd0);
        checkOutput("t1_sent", 128'(a_sent), 128'd1);

        // Width 128: 3-word packet, header counts 64-bit units
        clearLogs();
        applyStimulus(1, 3, 64'h1000, 1'b1, t);
        waitIdle(1, tr);
        checkOutput("t2_ready_back", 128'(tr), 128'(t + 5));
        expectWrite(1, "t2_hdr", 128'd6, t + 1);
        for (int k = 0; k < 3; k++) expectWrite(1, "t2_w", mkWord(64'h1000, k), t + 2 + k);
        checkOutput("t2_extra", 128'(qb.size()), 128'd0);
        checkOutput("t2_sent", 128'(b_sent), 128'd1);

        // Depth 4: 6-word packet splits into frames of 4 and 2
        clearLogs();
        c_splits = 0;
        applyStimulus(2, 6, 64'h300, 1'b1, t);
        waitIdle(2, tr);
        expectWrite(2, "t3_hdr1", 128'd4, acc[3] + 1);
        for (int k = 0; k < 4; k++) expectWrite(2, "t3_f1w", {64'd0, mkWord(64'h300, k)[63:0]}, acc[3] + 2 + k);
        expectWrite(2, "t3_hdr2", 128'd2, t + 1);
        expectWrite(2, "t3_f2w4", {64'd0, mkWord(64'h300, 4)[63:0]}, t + 2);
        expectWrite(2, "t3_f2w5", {64'd0, mkWord(64'h300, 5)[63:0]}, t + 3);
        checkOutput("t3_extra", 128'(qc.size()), 128'd0);
        checkOutput("t3_split_count", 128'(c_splits), 128'd1);
        checkOutput("t3_split_at", 128'(c_split_at), 128'(acc[3] + 1));
        checkOutput("t3_w4_accept", 128'(acc[4]), 128'(acc[3] + 6));
        checkOutput("t3_ready_back", 128'(tr), 128'(t + 4));
        checkOutput("t3_sent", 128'(c_sent), 128'd2);

        // Depth 4: exactly-full packet under FULL backpressure, no split
        clearLogs();
        splits_before = c_splits;
        full[2] = 1'b1;
        applyStimulus(2, 4, 64'h500, 1'b1, t);
        repeat (3) @(posedge clk);
        #1;
        full[2] = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            full[2] = ~full[2];
        end
        full[2] = 1'b0;
        waitIdle(2, tr);
        expectWrite(2, "t4_hdr", 128'd4, t + 4);
        for (int k = 0; k < 4; k++) expectWrite(2, "t4_w", {64'd0, mkWord(64'h500, k)[63:0]}, t + 6 + 2 * k);
        checkOutput("t4_extra", 128'(qc.size()), 128'd0);
        checkOutput("t4_no_split", 128'(c_splits), 128'(splits_before));
        checkOutput("t4_sent", 128'(c_sent), 128'd3);

        // Reset in the middle of a partially filled frame
        clearLogs();
        applyStimulus(2, 2, 64'h700, 1'b0, t);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t5_rst_ready", 128'(ready[2]), 128'd0);
        checkOutput("t5_rst_wren",  128'(wren[2]),  128'd0);
        checkOutput("t5_rst_split", 128'(split[2]), 128'd0);
        checkOutput("t5_rst_sent",  128'(c_sent),   128'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("t5_no_stale_hdr", 128'(qc.size()), 128'd0);
        applyStimulus(2, 1, 64'h900, 1'b1, t);
        waitIdle(2, tr);
        expectWrite(2, "t5_hdr", 128'd1, t + 1);
        expectWrite(2, "t5_w",   {64'd0, mkWord(64'h900, 0)[63:0]}, t + 2);
        checkOutput("t5_extra", 128'(qc.size()), 128'd0);
        checkOutput("t5_sent", 128'(c_sent), 128'd1);

        // Width 64: 1-word packet
        clearLogs();
        applyStimulus(0, 1, 64'hABC, 1'b1, t);
        waitIdle(0, tr);
        checkOutput("t6_ready_back", 128'(tr), 128'(t + 3));
        expectWrite(0, "t6_hdr", 128'd1,     t + 1);
        expectWrite(0, "t6_w",   128'h0ABC,  t + 2);
        checkOutput("t6_extra", 128'(qa.size()), 128'd0);
        checkOutput("t6_sent", 128'(a_sent), 128'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop if the sequence ever stalls
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
